// File: rtl/cmp_sweep.sv
// Sequential operand driver for a 4-bit equality comparator: sweeps an index range against a key.
// Optional build macro CMP_SWEEP_EARLY_EXIT_EN stops the sweep at the first matching index.
module cmp_sweep #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  key,
  input  logic [3:0]  lo,
  input  logic [3:0]  hi,
  output logic [3:0]  cmp_x,
  output logic [3:0]  cmp_y,
  output logic        cmp_req,
  input  logic        cmp_eq,
  output logic        busy,
  output logic        done,
  output logic [15:0] match_mask,
  output logic [4:0]  match_count,
  output logic        found,
  output logic [3:0]  first_idx
);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

`ifdef CMP_SWEEP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  // HOLD counts down from SETTLE-1 so the operand stays up for SETTLE+1 cycles in total.
  localparam logic [1:0] HOLD_LAST = (SETTLE > 0) ? 2'(SETTLE - 1) : 2'd0;
  localparam bit         USE_HOLD  = (SETTLE > 0);

  state_t      state;
  logic [4:0]  remaining;
  logic [1:0]  hold_cnt;

  logic [3:0]  span;
  logic        last_sample;

  // Modulo-16 distance gives the wrap-around sweep for lo > hi for free.
  assign span        = hi - lo;
  assign last_sample = (remaining == 5'd1) || (EARLY_EXIT && cmp_eq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= 5'd0;
      hold_cnt    <= 2'd0;
      cmp_x       <= 4'd0;
      cmp_y       <= 4'd0;
      cmp_req     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_mask  <= 16'd0;
      match_count <= 5'd0;
      found       <= 1'b0;
      first_idx   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cmp_x       <= lo;
            cmp_y       <= key;
            remaining   <= {1'b0, span} + 5'd1;
            hold_cnt    <= HOLD_LAST;
            cmp_req     <= 1'b1;
            busy        <= 1'b1;
            match_mask  <= 16'd0;
            match_count <= 5'd0;
            found       <= 1'b0;
            first_idx   <= 4'd0;
            state       <= USE_HOLD ? HOLD : SAMPLE;
          end
        end

        HOLD: begin
          if (hold_cnt == 2'd0) begin
            state <= SAMPLE;
          end else begin
            hold_cnt <= hold_cnt - 2'd1;
          end
        end

        SAMPLE: begin
          if (cmp_eq) begin
            match_mask  <= match_mask | (16'd1 << cmp_x);
            match_count <= match_count + 5'd1;
            if (!found) begin
              found     <= 1'b1;
              first_idx <= cmp_x;
            end
          end
          remaining <= remaining - 5'd1;
          if (last_sample) begin
            // cmp_x keeps the last swept index; only the handshake drops.
            cmp_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cmp_x    <= cmp_x + 4'd1;
            hold_cnt <= HOLD_LAST;
            state    <= USE_HOLD ? HOLD : SAMPLE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sweep.sv
// Directed bench for cmp_sweep: one instance with SETTLE=1 and one with SETTLE=0 on a shared clock.
module tb_cmp_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [3:0]  key, lo, hi;

  logic [3:0]  x0, y0, x1, y1, first0, first1;
  logic        req0, req1, eq0, eq1, busy0, busy1, done0, done1, found0, found1;
  logic [15:0] mask0, mask1;
  logic [4:0]  count0, count1;

  always #5 clk = ~clk;

  // Behavioural comparator on each operand bus.
  assign eq0 = (x0 == y0);
  assign eq1 = (x1 == y1);

  cmp_sweep #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .key(key), .lo(lo), .hi(hi),
    .cmp_x(x0), .cmp_y(y0), .cmp_req(req0), .cmp_eq(eq0), .busy(busy0), .done(done0),
    .match_mask(mask0), .match_count(count0), .found(found0), .first_idx(first0)
  );

  cmp_sweep #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key(key), .lo(lo), .hi(hi),
    .cmp_x(x1), .cmp_y(y1), .cmp_req(req1), .cmp_eq(eq1), .busy(busy1), .done(done1),
    .match_mask(mask1), .match_count(count1), .found(found1), .first_idx(first1)
  );

  bit          sel;
  logic [3:0]  m_x, m_first;
  logic        m_req, m_busy, m_done, m_found;
  logic [15:0] m_mask;
  logic [4:0]  m_count;

  assign m_x     = sel ? x1 : x0;
  assign m_req   = sel ? req1 : req0;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_done  = sel ? done1 : done0;
  assign m_mask  = sel ? mask1 : mask0;
  assign m_count = sel ? count1 : count0;
  assign m_found = sel ? found1 : found0;
  assign m_first = sel ? first1 : first0;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          lat;
  int          extra;
  logic [3:0]  xs [0:31];
  logic        e0_req, e0_busy;
  logic [3:0]  e0_x;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request on the selected instance and measure edges from E0 to done.
  task automatic run(input bit s, input logic [3:0] k, input logic [3:0] l,
                     input logic [3:0] h, input bit hold_start, output int latency);
    sel = s;
    key = k;
    lo  = l;
    hi  = h;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) begin
      start0 = 1'b0;
      start1 = 1'b0;
    end
    e0_x    = m_x;
    e0_req  = m_req;
    e0_busy = m_busy;
    xs[0]   = m_x;
    latency = -1;
    for (int i = 1; i <= 64; i++) begin
      if (hold_start) begin
        key = 4'(i);
        lo  = 4'(i + 1);
      end
      @(posedge clk); #1;
      if (i < 32) xs[i] = m_x;
      if (m_done) begin
        latency = i;
        break;
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic check_results(input string tag, input logic [15:0] mask,
                               input logic [4:0] count, input logic fnd, input logic [3:0] first);
    check({tag, "_mask"}, m_mask, mask);
    check({tag, "_count"}, m_count, count);
    check({tag, "_found"}, m_found, fnd);
    check({tag, "_first"}, m_first, first);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; key = 4'd0; lo = 4'd0; hi = 4'd0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_busy0", busy0, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_req1", req1, 1'b0);
    check("rst_x1", x1, 4'd0);
    check("rst_y1", y1, 4'd0);
    check("rst_mask1", mask1, 16'd0);
    check("rst_count1", count1, 5'd0);
    check("rst_first1", first1, 4'd0);

    // SETTLE=1, full range, key 5
    run(1'b1, 4'd5, 4'd0, 4'd15, 1'b0, lat);
    $display("txn full_s1: key=5 lo=0 hi=15 latency=%0d", lat);
    check("full_e0_x", e0_x, 4'd0);
    check("full_e0_req", e0_req, 1'b1);
    check("full_e0_busy", e0_busy, 1'b1);
    check("full_latency", lat, 32);
    check("full_busy_at_done", m_busy, 1'b0);
    check("full_req_at_done", m_req, 1'b0);
    check_results("full", 16'h0020, 5'd1, 1'b1, 4'd5);
    @(posedge clk); #1;
    check("full_done_pulse", m_done, 1'b0);
    check("full_mask_hold", m_mask, 16'h0020);

    // SETTLE=0, wrapped range with no match
    run(1'b0, 4'd3, 4'd14, 4'd2, 1'b0, lat);
    $display("txn wrap_s0: key=3 lo=14 hi=2 latency=%0d", lat);
    check("wrap_latency", lat, 5);
    check("wrap_x0", xs[0], 4'd14);
    check("wrap_x1", xs[1], 4'd15);
    check("wrap_x2", xs[2], 4'd0);
    check("wrap_x3", xs[3], 4'd1);
    check("wrap_x4", xs[4], 4'd2);
    check_results("wrap", 16'h0000, 5'd0, 1'b0, 4'd0);
    @(posedge clk); #1;

    // Single index
    run(1'b0, 4'd9, 4'd9, 4'd9, 1'b0, lat);
    $display("txn single_s0: key=9 lo=9 hi=9 latency=%0d", lat);
    check("single_latency", lat, 1);
    check_results("single", 16'h0200, 5'd1, 1'b1, 4'd9);
    @(posedge clk); #1;

    // lo = hi+1 sweeps all sixteen, match at index 0 after wrap
    run(1'b0, 4'd0, 4'd5, 4'd4, 1'b0, lat);
    $display("txn all16_s0: key=0 lo=5 hi=4 latency=%0d", lat);
    check("all16_latency", lat, 16);
    check_results("all16", 16'h0001, 5'd1, 1'b1, 4'd0);
    @(posedge clk); #1;

    // Start held high while busy, with inputs changing
    run(1'b1, 4'd7, 4'd3, 4'd8, 1'b1, lat);
    $display("txn hold_start_s1: key=7 lo=3 hi=8 latency=%0d", lat);
    check("hold_latency", lat, 12);
    check_results("hold", 16'h0080, 5'd1, 1'b1, 4'd7);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (m_done) extra++;
    end
    check("hold_extra_done", extra, 0);
    check("hold_idle_busy", m_busy, 1'b0);

    // Reset during HOLD of the 3rd index
    sel = 1'b1; key = 4'd1; lo = 4'd0; hi = 4'd15; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("txn midrst_s1: key=1 lo=0 hi=15 x_before_reset=%0d", x1);
    check("midrst_pre_x", x1, 4'd2);
    check("midrst_pre_mask", mask1, 16'h0002);
    check("midrst_pre_first", first1, 4'd1);
    rst = 1'b1;
    #1;
    check("midrst_x", x1, 4'd0);
    check("midrst_y", y1, 4'd0);
    check("midrst_req", req1, 1'b0);
    check("midrst_busy", busy1, 1'b0);
    check("midrst_done", done1, 1'b0);
    check_results("midrst", 16'h0000, 5'd0, 1'b0, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(1'b1, 4'd6, 4'd4, 4'd6, 1'b0, lat);
    $display("txn post_rst_s1: key=6 lo=4 hi=6 latency=%0d", lat);
    check("postrst_e0_x", e0_x, 4'd4);
    check("postrst_latency", lat, 6);
    check_results("postrst", 16'h0040, 5'd1, 1'b1, 4'd6);
    @(posedge clk); #1;

    // Early-exit scenario: match at offset 2 of a 9-index range
    run(1'b1, 4'd4, 4'd2, 4'd10, 1'b0, lat);
    $display("txn early_s1: key=4 lo=2 hi=10 latency=%0d", lat);
`ifdef CMP_SWEEP_EARLY_EXIT_EN
    check("early_latency", lat, 6);
`else
    check("early_latency", lat, 18);
`endif
    check_results("early", 16'h0010, 5'd1, 1'b1, 4'd4);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_sweep.md
# cmp_sweep

Sequential operand driver for the 4-bit equality comparator in the comparison unit. On a start request it latches a 4-bit key and an index range, drives each index in the range against the key on the comparator's operand bus, and samples the 1-bit equality result. It accumulates a per-index match mask, a match count and the first matching index, then reports completion. It sits between the ALU control path and the combinational comparator, acting as the requesting side of that interface.

## Interface
- `SETTLE`, default 1: extra hold cycles per operand before `cmp_eq` is sampled. Legal range 0..3.
- `clk` in 1: clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: sweep request, sampled only in IDLE.
- `key` in 4: value compared against every index; latched on start.
- `lo` in 4: first index; latched on start.
- `hi` in 4: last index (inclusive); latched on start.
- `cmp_x` out 4: operand x to the comparator (current index).
- `cmp_y` out 4: operand y to the comparator (latched key).
- `cmp_req` out 1: high while operands on `cmp_x`/`cmp_y` are valid.
- `cmp_eq` in 1: comparator result, 1 when x == y.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle completion pulse.
- `match_mask` out 16: bit i set when index i matched.
- `match_count` out 5: number of matches, 0..16.
- `found` out 1: at least one match.
- `first_idx` out 4: first matching index in sweep order; 0 when `found`=0.

## Operation
- States: IDLE, HOLD, SAMPLE, DONE.
- IDLE, start=1:
  - Latch key, lo and hi; set index = lo.
  - Clear `match_mask`, `match_count`, `found` and `first_idx`.
  - Compute remaining = ((hi − lo) mod 16) + 1, a 5-bit value in the range 1..16.
  - Go to HOLD if SETTLE>0, else go to SAMPLE.
- HOLD: wait SETTLE cycles with operands stable, then go to SAMPLE.
- SAMPLE, on each edge:
  - Register `cmp_eq`.
  - If it is 1:
    - Set `match_mask[index]` and increment `match_count`.
    - If `found` was 0, set `first_idx` = index and `found` = 1.
  - Decrement remaining.
  - If remaining reaches 0, go to DONE.
  - Otherwise increment index (mod 16, wrapping 15→0) and go to HOLD, or stay in SAMPLE when SETTLE=0.
- DONE: one cycle, then IDLE.
- Range wrap: lo > hi sweeps lo..15 then 0..hi. lo == hi sweeps exactly one index. lo = hi+1 (mod 16) sweeps all 16 indices.
- `start` in any state other than IDLE is ignored; no queuing.
- Result outputs hold their values from DONE until the next accepted start.
- Reset at any time, including mid-sweep: return to IDLE; every output goes to 0; the latched key and range are discarded.

## Timing
- Reset values: `cmp_x`=0, `cmp_y`=0, `cmp_req`=0, `busy`=0, `done`=0, `match_mask`=0, `match_count`=0, `found`=0, `first_idx`=0.
- Start accepted at edge E0. From E0, `cmp_x` = lo, `cmp_y` = key, and `cmp_req` = `busy` = 1.
- Each operand is held for SETTLE+1 cycles. `cmp_eq` is sampled on the last edge of that window, and `cmp_x` advances on the same edge.
- For N swept indices, `done` is high for the single cycle after edge E0 + N·(SETTLE+1). `busy` and `cmp_req` fall on that same edge.
- Result registers are final when `done` is high.
- Earliest next start is accepted on the edge that ends DONE, plus one cycle, i.e. while in IDLE.
- `cmp_eq` is treated as combinational from `cmp_x`/`cmp_y`. No other timing dependency on the comparator.

## Configuration
- `CMP_SWEEP_EARLY_EXIT_EN` defined: the sweep ends at the first matching index.
  - SAMPLE goes to DONE on the first `cmp_eq`=1.
  - `match_count` is at most 1 and `match_mask` has at most one bit set.
  - `done` arrives (k+1)·(SETTLE+1) cycles after E0, where k is the offset of the match from lo.
- Undefined: the full range is always swept, as described above.

## Test plan
- Reset mid-sweep: assert `rst` during HOLD of the 3rd index -> all outputs are 0 immediately; a new start afterwards sweeps correctly from its own lo.
- SETTLE=1, key=5, lo=0, hi=15 -> `done` 32 cycles after start; `match_mask`=0x0020, `match_count`=1, `found`=1, `first_idx`=5.
- SETTLE=0, key=3, lo=14, hi=2 (wrap) -> `cmp_x` sequence 14,15,0,1,2; `done` 5 cycles after start; `found`=0, `first_idx`=0, `match_mask`=0.
- Key=9, lo=9, hi=9 -> single operand; `match_mask`=0x0200, `match_count`=1.
- Start re-asserted every cycle while busy -> ignored; exactly one `done` pulse; results unchanged from the first request.
- With `CMP_SWEEP_EARLY_EXIT_EN`, SETTLE=1, key=4, lo=2, hi=10 -> `done` 6 cycles after start; `first_idx`=4, `match_count`=1. Without the macro, `done` arrives 18 cycles after start.
